bist_controller: RTL and testbench

Sequencing controller for the BIST datapath around the 4-bit circuit-under-test (CUT). On request it switches the CUT inputs from functional operands to an on-chip LFSR pattern source and runs a fixed number of patterns. It compacts the CUT responses into a 32-bit MISR and compares the final signature against a golden value, reporting pass/fail. Outside a test it passes functional operands straight through to the CUT.

---
 rtl/bist_pkg.sv | 26 ++
 rtl/bist_misr.sv | 35 +++
 rtl/bist_controller.sv | 170 +++++++++++++++++
 tb/tb_bist_controller.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST sequencing datapath around the 4-bit CUT.
package bist_pkg;

  localparam int OPND_W = 4;
  localparam int RES_W  = 8;
  localparam int SIG_W  = 32;
  localparam int LFSR_W = 2 * OPND_W;

  localparam logic [LFSR_W-1:0] LFSR_SEED = 8'h01;
  localparam logic [SIG_W-1:0]  MISR_POLY = 32'h0040_0007;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_RUN,
    ST_FLUSH,
    ST_COMPARE,
    ST_DONE
  } state_e;

  // Fibonacci LFSR, shifting left; taps 7,5,4,3 give a maximal-length sequence.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return {cur[LFSR_W-2:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
  endfunction

endpackage

// File: rtl/bist_misr.sv
// 32-bit multiple-input signature register with synchronous clear and 8-bit parallel input.
module bist_misr
  import bist_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [RES_W-1:0] din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] misr_q, misr_d;

  always_comb begin
    misr_d = misr_q;
    if (clr) begin
      misr_d = '0;
    end else if (en) begin
      misr_d = ({misr_q[SIG_W-2:0], 1'b0} ^ (misr_q[SIG_W-1] ? MISR_POLY : '0))
               ^ {{(SIG_W-RES_W){1'b0}}, din};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misr_q <= '0;
    end else begin
      misr_q <= misr_d;
    end
  end

  assign sig = misr_q;

endmodule

// File: rtl/bist_controller.sv
// BIST sequencer: muxes LFSR patterns onto the CUT, compacts responses in a MISR,
// and checks the final signature against GOLDEN.
//   state   | meaning
//   IDLE    | functional pass-through, waiting for start
//   SEED    | reload LFSR, clear MISR and valid pipe, load pattern counter
//   RUN     | apply one LFSR pattern per cycle, PATTERNS cycles
//   FLUSH   | drain the CUT_LAT-deep valid pipe
//   COMPARE | capture signature and pass flag
//   DONE    | one-cycle done pulse, back on functional operands
module bist_controller
  import bist_pkg::*;
#(
  parameter int unsigned      PATTERNS = 15,
  parameter int unsigned      CUT_LAT  = 1,
  parameter logic [SIG_W-1:0] GOLDEN   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic [OPND_W-1:0] a_in,
  input  logic [OPND_W-1:0] b_in,
  input  logic [RES_W-1:0]  cut_y,
  output logic [OPND_W-1:0] cut_a,
  output logic [OPND_W-1:0] cut_b,
  output logic              test_mode,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  signature
);

  state_e state_q, state_d;

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              tm_q, tm_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [SIG_W-1:0]  sig_q, sig_d;

  logic             pipe_clr, pipe_step, pipe_push, pipe_drain, vld_out;
  logic             misr_clr, misr_en;
  logic [SIG_W-1:0] misr;

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    cnt_d     = cnt_q;
    pass_d    = pass_q;
    sig_d     = sig_q;
    pipe_clr  = 1'b0;
    pipe_step = 1'b0;
    pipe_push = 1'b0;
    misr_clr  = 1'b0;
    if (en) begin
      case (state_q)
        ST_IDLE: begin
          if (start) state_d = ST_SEED;
        end
        ST_SEED: begin
          lfsr_d   = LFSR_SEED;
          cnt_d    = 8'(PATTERNS - 1);
          pass_d   = 1'b0;
          pipe_clr = 1'b1;
          misr_clr = 1'b1;
          state_d  = ST_RUN;
        end
        ST_RUN: begin
          pipe_step = 1'b1;
          pipe_push = 1'b1;
          lfsr_d    = lfsr_next(lfsr_q);
          // Down-counter: terminal count marks the last pattern.
          if (cnt_q == 8'd0) begin
            state_d = (CUT_LAT == 0) ? ST_COMPARE : ST_FLUSH;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        ST_FLUSH: begin
          pipe_step = 1'b1;
          if (pipe_drain) state_d = ST_COMPARE;
        end
        ST_COMPARE: begin
          sig_d   = misr;
          pass_d  = (misr == GOLDEN);
          state_d = ST_DONE;
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    tm_d   = (state_d inside {ST_SEED, ST_RUN, ST_FLUSH, ST_COMPARE});
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lfsr_q  <= LFSR_SEED;
      cnt_q   <= '0;
      tm_q    <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      sig_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      tm_q    <= tm_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      sig_q   <= sig_d;
    end
  end

  // With zero CUT latency the response is valid in the same cycle as the pattern.
  if (CUT_LAT == 0) begin : g_nopipe
    assign vld_out    = (state_q == ST_RUN);
    assign pipe_drain = 1'b1;
  end else begin : g_pipe
    logic [CUT_LAT-1:0] pipe_q, pipe_d, pipe_sh;

    always_comb begin
      pipe_sh = pipe_q << 1;
      pipe_d  = pipe_q;
      if (pipe_clr) begin
        pipe_d = '0;
      end else if (pipe_step) begin
        pipe_d    = pipe_sh;
        pipe_d[0] = pipe_push;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pipe_q <= '0;
      end else begin
        pipe_q <= pipe_d;
      end
    end

    assign vld_out    = pipe_q[CUT_LAT-1];
    assign pipe_drain = (pipe_sh == '0);
  end

  assign misr_en = en & vld_out;

  bist_misr u_misr (
    .clk (clk),
    .rst (rst),
    .en  (misr_en),
    .clr (misr_clr),
    .din (cut_y),
    .sig (misr)
  );

  assign cut_a     = tm_q ? lfsr_q[7:4] : a_in;
  assign cut_b     = tm_q ? lfsr_q[3:0] : b_in;
  assign test_mode = tm_q;
  assign busy      = tm_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;

endmodule

// File: tb/tb_bist_controller.sv
// Scoreboard bench for bist_controller: three instances (P=4/L=1, defaults, P=3/L=0) share stimulus.
module tb_bist_controller;

  function automatic logic [7:0] prod(input logic [3:0] a, input logic [3:0] b);
    return {4'b0, a} * {4'b0, b};
  endfunction

  // Reference signature: 4x4 multiplier CUT driven by the LFSR sequence from seed 8'h01.
  function automatic logic [31:0] calc_sig(input int p, input bit stuck);
    logic [7:0]  l;
    logic [31:0] m;
    logic [7:0]  y;
    l = 8'h01;
    m = 32'h0;
    for (int i = 0; i < p; i++) begin
      y = {4'b0, l[7:4]} * {4'b0, l[3:0]};
      if (stuck) y[0] = 1'b1;
      m = ({m[30:0], 1'b0} ^ (m[31] ? 32'h0040_0007 : 32'h0)) ^ {24'h0, y};
      l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    end
    return m;
  endfunction

  localparam logic [31:0] GOLD15 = calc_sig(15, 1'b0);
  localparam logic [31:0] STK15  = calc_sig(15, 1'b1);

  logic clk, rst, en, start, stuck;
  logic [3:0] a_in, b_in;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  logic [3:0]  cut_a4, cut_b4, cut_a15, cut_b15, cut_a0, cut_b0;
  logic [7:0]  y4_q, y15_q, cut_y4, cut_y15, cut_y0;
  logic        tm4, busy4, done4, pass4, tm15, busy15, done15, pass15;
  logic        tm0, busy0, done0, pass0;
  logic [31:0] sig4, sig15, sig0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered CUT stage shares the global enable so it freezes with the controller.
  always @(posedge clk) if (en) y4_q  <= prod(cut_a4, cut_b4);
  always @(posedge clk) if (en) y15_q <= prod(cut_a15, cut_b15);
  assign cut_y4  = y4_q  | {7'b0, stuck};
  assign cut_y15 = y15_q | {7'b0, stuck};
  assign cut_y0  = prod(cut_a0, cut_b0) | {7'b0, stuck};

  bist_controller #(.PATTERNS(4), .CUT_LAT(1), .GOLDEN(32'h0)) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .start(start), .a_in(a_in), .b_in(b_in),
    .cut_y(cut_y4), .cut_a(cut_a4), .cut_b(cut_b4), .test_mode(tm4), .busy(busy4),
    .done(done4), .pass(pass4), .signature(sig4));

  bist_controller #(.GOLDEN(GOLD15)) u_dut15 (
    .clk(clk), .rst(rst), .en(en), .start(start), .a_in(a_in), .b_in(b_in),
    .cut_y(cut_y15), .cut_a(cut_a15), .cut_b(cut_b15), .test_mode(tm15), .busy(busy15),
    .done(done15), .pass(pass15), .signature(sig15));

  bist_controller #(.PATTERNS(3), .CUT_LAT(0), .GOLDEN(32'h0)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .start(start), .a_in(a_in), .b_in(b_in),
    .cut_y(cut_y0), .cut_a(cut_a0), .cut_b(cut_b0), .test_mode(tm0), .busy(busy0),
    .done(done0), .pass(pass0), .signature(sig0));

  typedef struct {
    int          cyc;
    logic        pass;
    logic [31:0] sig;
  } done_t;

  typedef struct {
    int         cyc;
    logic       chk_ab;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
  } probe_t;

  done_t  q_done[3][$];
  probe_t q_probe[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon_done(input int k, input logic d, input logic p, input logic [31:0] s);
    done_t e;
    if (d) begin
      check($sformatf("dut%0d_done_expected", k), 32'(q_done[k].size() != 0), 32'd1);
      if (q_done[k].size() != 0) begin
        e = q_done[k].pop_front();
        check($sformatf("dut%0d_done_cycle", k), cyc, e.cyc);
        check($sformatf("dut%0d_pass", k), 32'(p), 32'(e.pass));
        check($sformatf("dut%0d_signature", k), s, e.sig);
      end
    end
  endtask

  always @(negedge clk) begin
    probe_t pr;
    mon_done(0, done4, pass4, sig4);
    mon_done(1, done15, pass15, sig15);
    mon_done(2, done0, pass0, sig0);
    while (q_probe.size() != 0 && q_probe[0].cyc <= cyc) begin
      pr = q_probe.pop_front();
      check("probe_cycle", cyc, pr.cyc);
      check("dut4_busy", 32'(busy4), 32'(pr.busy));
      if (pr.chk_ab) begin
        check("dut4_cut_a", 32'(cut_a4), 32'(pr.a));
        check("dut4_cut_b", 32'(cut_b4), 32'(pr.b));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push_done(input int k, input int c, input logic p, input logic [31:0] s);
    done_t e;
    e.cyc = c; e.pass = p; e.sig = s;
    q_done[k].push_back(e);
  endtask

  task automatic push_probe(input int c, input logic chk, input logic [3:0] a,
                            input logic [3:0] b, input logic busy);
    probe_t e;
    e.cyc = c; e.chk_ab = chk; e.a = a; e.b = b; e.busy = busy;
    q_probe.push_back(e);
  endtask

  task automatic clear_queues();
    for (int k = 0; k < 3; k++) q_done[k].delete();
    q_probe.delete();
  endtask

  // Uninterrupted run on all three instances with the given expected results.
  task automatic plain_run(input logic p4, input logic [31:0] s4, input logic p15,
                           input logic [31:0] s15, input logic p0, input logic [31:0] s0,
                           input bit probes);
    int c0;
    tick();
    start = 1'b1;
    c0 = cyc;
    if (probes) begin
      push_probe(c0, 1'b1, 4'hA, 4'hB, 1'b0);
      push_probe(c0 + 1, 1'b0, 4'h0, 4'h0, 1'b1);
      for (int i = 0; i < 4; i++) push_probe(c0 + 2 + i, 1'b1, 4'h0, 4'(1 << i), 1'b1);
      push_probe(c0 + 6, 1'b1, 4'h1, 4'h1, 1'b1);
      push_probe(c0 + 7, 1'b1, 4'h1, 4'h1, 1'b1);
      push_probe(c0 + 8, 1'b1, 4'hA, 4'hB, 1'b0);
    end
    push_done(0, c0 + 8, p4, s4);
    push_done(1, c0 + 19, p15, s15);
    push_done(2, c0 + 6, p0, s0);
    tick();
    start = 1'b0;
    wait_cyc(c0 + 24);
  endtask

  initial begin
    int c0;
    rst = 1'b1; en = 1'b1; start = 1'b0; stuck = 1'b0;
    a_in = 4'hA; b_in = 4'hB;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("rst_cut_a", 32'(cut_a4), 32'hA);
    check("rst_cut_b", 32'(cut_b4), 32'hB);
    check("rst_busy", 32'(busy4), 32'd0);
    check("rst_test_mode", 32'(tm4), 32'd0);
    check("rst_done", 32'(done4), 32'd0);
    check("rst_pass", 32'(pass4), 32'd0);
    check("rst_signature", sig15, 32'd0);

    // Fault-free run: pattern sequence, busy window, done timing, pass
    plain_run(1'b1, 32'h0, 1'b1, GOLD15, 1'b1, 32'h0, 1'b1);
    check("pass_sticky_idle", 32'(pass15), 32'd1);

    // cut_y[0] stuck-at-1
    stuck = 1'b1;
    plain_run(1'b0, 32'hF, 1'b0, STK15, 1'b0, 32'h7, 1'b0);
    stuck = 1'b0;
    check("fail_sticky_idle", 32'(pass15), 32'd0);
    check("stuck_sig_differs", 32'(sig15 != GOLD15), 32'd1);

    // Enable dropped for 5 cycles mid-RUN
    tick();
    start = 1'b1;
    c0 = cyc;
    push_probe(c0 + 2, 1'b1, 4'h0, 4'h1, 1'b1);
    push_probe(c0 + 3, 1'b1, 4'h0, 4'h2, 1'b1);
    for (int i = 4; i <= 9; i++) push_probe(c0 + i, 1'b1, 4'h0, 4'h4, 1'b1);
    push_probe(c0 + 10, 1'b1, 4'h0, 4'h8, 1'b1);
    push_probe(c0 + 11, 1'b1, 4'h1, 4'h1, 1'b1);
    push_probe(c0 + 12, 1'b1, 4'h1, 4'h1, 1'b1);
    push_probe(c0 + 13, 1'b1, 4'hA, 4'hB, 1'b0);
    push_done(0, c0 + 13, 1'b1, 32'h0);
    push_done(1, c0 + 24, 1'b1, GOLD15);
    push_done(2, c0 + 11, 1'b1, 32'h0);
    tick();
    start = 1'b0;
    wait_cyc(c0 + 4);
    en = 1'b0;
    wait_cyc(c0 + 9);
    en = 1'b1;
    wait_cyc(c0 + 30);

    // Reset asserted while dut4 is in FLUSH
    tick();
    start = 1'b1;
    c0 = cyc;
    tick();
    start = 1'b0;
    wait_cyc(c0 + 6);
    check("pre_rst_busy", 32'(busy4), 32'd1);
    check("pre_rst_cut_a", 32'(cut_a4), 32'h1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy4), 32'd0);
    check("mid_rst_test_mode", 32'(tm15), 32'd0);
    check("mid_rst_cut_a", 32'(cut_a4), 32'hA);
    check("mid_rst_cut_b", 32'(cut_b15), 32'hB);
    check("mid_rst_pass", 32'(pass15), 32'd0);
    check("mid_rst_signature", sig15, 32'd0);
    clear_queues();
    tick();
    tick();
    rst = 1'b0;

    // New run after reset, with a start pulse issued while busy
    tick();
    start = 1'b1;
    c0 = cyc;
    push_done(0, c0 + 8, 1'b1, 32'h0);
    push_done(1, c0 + 19, 1'b1, GOLD15);
    push_done(2, c0 + 6, 1'b1, 32'h0);
    tick();
    start = 1'b0;
    wait_cyc(c0 + 4);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_cyc(c0 + 30);
    check("final_pass", 32'(pass15), 32'd1);
    check("final_signature", sig15, GOLD15);

    for (int k = 0; k < 3; k++) check($sformatf("dut%0d_pending_done", k), q_done[k].size(), 32'd0);
    check("pending_probes", q_probe.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
